mab_arbiter: RTL and testbench

//   Owns the memory address bus (MAB) and the write strobe (MW).

---
 rtl/msp430_bus_pkg.sv | 21 ++
 rtl/mab_req_pick.sv | 38 +++
 rtl/mab_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mab_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msp430_bus_pkg.sv
// Shared bus definitions: FSM state encoding, requester IDs and requester count
// used by the memory address bus arbiter and its winner-select logic.
package msp430_bus_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'd0,
    REQ_SRC   = 2'd1,
    REQ_DST   = 2'd2,
    REQ_STACK = 2'd3
  } req_id_e;

endpackage

// File: rtl/mab_req_pick.sv
// Combinational winner select for the MAB arbiter.
// MAB_ARB_RR_EN selects round-robin starting after last_id; otherwise fixed priority 3>2>1>0.
module mab_req_pick
  import msp430_bus_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last_id,
  output logic [1:0]      id,
  output logic            valid
);

  assign valid = |req;

`ifdef MAB_ARB_RR_EN
  logic [1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    id  = 2'd0;
    idx = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_id + 2'(k);
      if (req[idx]) id = idx;
    end
  end
`else
  logic unused_last_id;
  assign unused_last_id = ^last_id;

  always_comb begin
    id = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) id = 2'(i);
    end
  end
`endif

endmodule

// File: rtl/mab_arbiter.sv
// Memory address bus arbiter: one FSM shares MAB/MDB_in/MW among four requesters.
// Define MAB_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module mab_arbiter
  import msp430_bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      rdata,
  output logic               err,
  output logic               busy,
  output logic [AW-1:0]      MAB,
  output logic [DW-1:0]      MDB_in,
  output logic               MW,
  input  logic [DW-1:0]      MDB_out,
  input  logic               mem_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef MAB_ARB_RR_EN
  localparam logic [1:0] LAST_ID_RST = REQ_STACK;
`else
  localparam logic [1:0] LAST_ID_RST = REQ_FETCH;
`endif

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [AW-1:0]     mab_q, mab_d;
  logic [DW-1:0]     mdb_in_q, mdb_in_d;
  logic              mw_q, mw_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [TW-1:0]     tmo_inc;
  logic [1:0]        last_id_q, last_id_d;
  logic [1:0]        id_q, id_d;
  logic              we_q, we_d;

  logic [1:0]        pick_id;
  logic              pick_valid;
  logic [AW-1:0]     addr_arr  [NREQ];
  logic [DW-1:0]     wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AW +: AW];
    assign wdata_arr[i] = req_wdata[i*DW +: DW];
  end

  mab_req_pick u_pick (
    .req     (req),
    .last_id (last_id_q),
    .id      (pick_id),
    .valid   (pick_valid)
  );

  assign tmo_inc = tmo_q + TW'(1);

  // The bus is driven straight from the winner so memory sees it during ISSUE.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    busy_d    = busy_q;
    mab_d     = mab_q;
    mdb_in_d  = mdb_in_q;
    mw_d      = mw_q;
    tmo_d     = tmo_q;
    last_id_d = last_id_q;
    id_d      = id_q;
    we_d      = we_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          id_d     = pick_id;
          we_d     = req_we[pick_id];
          mab_d    = addr_arr[pick_id];
          mdb_in_d = wdata_arr[pick_id];
          mw_d     = req_we[pick_id];
          busy_d   = 1'b1;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        tmo_d = tmo_inc;
        if (mem_ready) begin
          rdata_d      = we_q ? '0 : MDB_out;
          err_d        = 1'b0;
          mw_d         = 1'b0;
          gnt_d        = '0;
          gnt_d[id_q]  = 1'b1;
          state_d      = RESP;
        end else if (tmo_inc == TW'(TIMEOUT)) begin
          rdata_d      = '0;
          err_d        = 1'b1;
          mw_d         = 1'b0;
          gnt_d        = '0;
          gnt_d[id_q]  = 1'b1;
          state_d      = RESP;
        end
      end

      RESP: begin
        last_id_d = id_q;
        gnt_d     = '0;
        err_d     = 1'b0;
        rdata_d   = '0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      mab_q     <= '0;
      mdb_in_q  <= '0;
      mw_q      <= 1'b0;
      tmo_q     <= '0;
      last_id_q <= LAST_ID_RST;
      id_q      <= 2'd0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      mab_q     <= mab_d;
      mdb_in_q  <= mdb_in_d;
      mw_q      <= mw_d;
      tmo_q     <= tmo_d;
      last_id_q <= last_id_d;
      id_q      <= id_d;
      we_q      <= we_d;
    end
  end

  assign gnt    = gnt_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign MAB    = mab_q;
  assign MDB_in = mdb_in_q;
  assign MW     = mw_q;

endmodule

// File: tb/tb_mab_arbiter.sv
// Scoreboard bench for mab_arbiter: a transaction-level requester/memory model predicts
// each grant, and a negedge monitor pops and compares whenever gnt is presented.
module tb_mab_arbiter;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

`ifdef MAB_ARB_RR_EN
  localparam logic [1:0] LAST_RST = 2'd3;
`else
  localparam logic [1:0] LAST_RST = 2'd0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req = '0;
  logic [3:0]      req_we = '0;
  logic [4*AW-1:0] req_addr = '0;
  logic [4*DW-1:0] req_wdata = '0;
  logic [3:0]      gnt;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            busy;
  logic [AW-1:0]   MAB;
  logic [DW-1:0]   MDB_in;
  logic            MW;
  logic [DW-1:0]   MDB_out = '0;
  logic            mem_ready = 1'b0;

  mab_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .MAB       (MAB),
    .MDB_in    (MDB_in),
    .MW        (MW),
    .MDB_out   (MDB_out),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [3:0]    gnt;
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  // Requester-side model: what each requester currently asks for
  logic [3:0]    pend = '0;
  logic [AW-1:0] m_addr  [4];
  logic          m_we    [4];
  logic [DW-1:0] m_wdata [4];
  logic [1:0]    last_m = LAST_RST;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cycle);
  endtask

  // Reference arbitration: scan an ordered candidate list and take the first pending one
  function automatic logic [1:0] model_pick(input logic [3:0] p, input logic [1:0] last);
    int order [4];
    for (int k = 0; k < 4; k++) begin
`ifdef MAB_ARB_RR_EN
      order[k] = (int'(last) + 1 + k) % 4;
`else
      order[k] = 3 - k;
`endif
    end
    for (int k = 0; k < 4; k++) begin
      if (p[order[k]]) return 2'(order[k]);
    end
    return 2'd0;
  endfunction

  task automatic drive_req();
    req = pend;
    for (int i = 0; i < 4; i++) begin
      req_we[i]              = m_we[i];
      req_addr[i*AW +: AW]   = m_addr[i];
      req_wdata[i*DW +: DW]  = m_wdata[i];
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i]    = 1'b1;
    m_we[i]    = we;
    m_addr[i]  = a;
    m_wdata[i] = d;
  endtask

  // One access: called just after a clock edge with the DUT idle in the coming cycle.
  // lat = number of WAIT cycles before mem_ready (mem_ready lands in WAIT cycle lat+1).
  task automatic applyStimulus(input int lat, input bit add_new, input logic [DW-1:0] rd);
    int         w;
    logic [1:0] win;
    bit         to;
    exp_t       e;
    if (add_new) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          set_req(i, 1'($urandom), 16'($urandom), 16'($urandom));
        end
      end
    end
    drive_req();
    if (pend == 4'b0) begin
      @(posedge clk); #1;
      checkOutput("idle_no_req_busy", 32'(busy), 32'd0);
      return;
    end
    win = model_pick(pend, last_m);
    to  = (lat >= TIMEOUT);
    w   = to ? TIMEOUT : lat + 1;
    e.gnt   = 4'b0001 << win;
    e.rdata = (to || m_we[win]) ? '0 : rd;
    e.err   = to;
    e.cyc   = cycle + w + 2;
    exp_q.push_back(e);

    @(posedge clk); #1;
    checkOutput("issue_MAB", 32'(MAB), 32'(m_addr[win]));
    checkOutput("issue_MW", 32'(MW), 32'(m_we[win]));
    checkOutput("issue_MDB_in", 32'(MDB_in), 32'(m_wdata[win]));
    checkOutput("issue_busy", 32'(busy), 32'd1);

    @(posedge clk); #1;
    for (int n = 1; n <= w; n++) begin
      checkOutput("wait_MW", 32'(MW), 32'(m_we[win]));
      checkOutput("wait_MAB", 32'(MAB), 32'(m_addr[win]));
      if (!to && n == lat + 1) begin
        mem_ready = 1'b1;
        MDB_out   = rd;
      end else begin
        mem_ready = 1'b0;
        MDB_out   = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    checkOutput("resp_MW", 32'(MW), 32'd0);
    checkOutput("resp_busy", 32'(busy), 32'd1);

    @(posedge clk); #1;
    pend[win] = 1'b0;
    last_m    = win;
    drive_req();
    checkOutput("exit_gnt", 32'(gnt), 32'd0);
    checkOutput("exit_rdata", 32'(rdata), 32'd0);
    checkOutput("exit_err", 32'(err), 32'd0);
    checkOutput("exit_busy", 32'(busy), 32'd0);
    checkOutput("exit_MAB_hold", 32'(MAB), 32'(m_addr[win]));
  endtask

  // Monitor: every presented grant must match the oldest expected response
  always @(negedge clk) begin
    if (rst_n && gnt != 4'b0) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_gnt", 32'(gnt), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("gnt", 32'(gnt), 32'(mon_e.gnt));
        checkOutput("rdata", 32'(rdata), 32'(mon_e.rdata));
        checkOutput("err", 32'(err), 32'(mon_e.err));
        checkOutput("gnt_cycle", 32'(cycle), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_addr[i]  = '0;
      m_we[i]    = 1'b0;
      m_wdata[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_rdata", 32'(rdata), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_MAB", 32'(MAB), 32'd0);
    checkOutput("rst_MDB_in", 32'(MDB_in), 32'd0);
    checkOutput("rst_MW", 32'(MW), 32'd0);
    rst_n  = 1'b1;
    last_m = LAST_RST;

    $display("[TB] fetch read");
    set_req(0, 1'b0, 16'hC000, 16'h0000);
    applyStimulus(0, 1'b0, 16'h4031);

    $display("[TB] stack write");
    set_req(3, 1'b1, 16'h03FE, 16'h1234);
    applyStimulus(2, 1'b0, 16'hBEEF);

    $display("[TB] all four requesting");
    for (int i = 0; i < 4; i++) set_req(i, 1'($urandom), 16'($urandom), 16'($urandom));
    for (int r = 0; r < 4; r++) applyStimulus(r, 1'b0, 16'($urandom));

    $display("[TB] timeout and ready-at-timeout");
    set_req(2, 1'b0, 16'h0200, 16'h0000);
    applyStimulus(TIMEOUT + 5, 1'b0, 16'hAAAA);
    set_req(1, 1'b0, 16'h0210, 16'h0000);
    applyStimulus(TIMEOUT - 1, 1'b0, 16'h5A5A);
    set_req(3, 1'b1, 16'h0220, 16'h7777);
    applyStimulus(TIMEOUT, 1'b0, 16'h1111);

    $display("[TB] reset during write WAIT");
    set_req(3, 1'b1, 16'h03FE, 16'h1234);
    drive_req();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rstmid_MW_before", 32'(MW), 32'd1);
    rst_n = 1'b0;
    pend  = '0;
    drive_req();
    @(posedge clk); #1;
    checkOutput("rstmid_MW", 32'(MW), 32'd0);
    checkOutput("rstmid_gnt", 32'(gnt), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_MAB", 32'(MAB), 32'd0);
    rst_n  = 1'b1;
    last_m = LAST_RST;
    set_req(1, 1'b0, 16'h1000, 16'h0000);
    applyStimulus(1, 1'b0, 16'hC0DE);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 150; r++) begin
      int lat;
      if ($urandom_range(7, 0) == 0) lat = int'($urandom_range(TIMEOUT + 2, TIMEOUT - 3));
      else lat = int'($urandom_range(3, 0));
      applyStimulus(lat, 1'b1, 16'($urandom));
    end

    pend = '0;
    drive_req();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
